// File: rtl/clock_pkg.sv
// Shared definitions for the clock slice: FSM state encoding and BCD digit limits.
package clock_pkg;

   typedef enum logic {
      RUN = 1'b0,
      SET = 1'b1
   } state_t;

   localparam logic [3:0] UNITS_MAX = 4'd9;
   localparam logic [2:0] TENS_MAX  = 3'd5;

endpackage

// File: rtl/minutes_bcd_step.sv
// Combinational +/-1 minute step on a two-digit BCD value 00..59, flagging the 59<->00 wrap.
module minutes_bcd_step
   import clock_pkg::*;
(
   input  logic [2:0] leftMin,
   input  logic [3:0] rightMin,
   input  logic       inc,
   input  logic       dec,
   output logic [2:0] nextLeft,
   output logic [3:0] nextRight,
   output logic       wrap
);

   // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      nextLeft  = leftMin;
      nextRight = rightMin;
      wrap      = 1'b0;
      if (inc && !dec) begin
         if (rightMin != UNITS_MAX) begin
            nextRight = rightMin + 4'd1;
         end else begin
            nextRight = 4'd0;
            if (leftMin != TENS_MAX) begin
               nextLeft = leftMin + 3'd1;
            end else begin
               nextLeft = 3'd0;
               wrap     = 1'b1;
            end
         end
      end else if (dec && !inc) begin
         if (rightMin != 4'd0) begin
            nextRight = rightMin - 4'd1;
         end else begin
            nextRight = UNITS_MAX;
            if (leftMin != 3'd0) begin
               nextLeft = leftMin - 3'd1;
            end else begin
               nextLeft = TENS_MAX;
               wrap     = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/minutes_counter.sv
// Minutes counter with RUN/SET modes: tick-driven BCD minutes in RUN, button
// editing with auto-repeat in SET, and a one-cycle hour carry on 59->00.
module minutes_counter
   import clock_pkg::*;
#(
   parameter int TICKS_PER_MIN = 60,
   parameter int REPEAT_CYCLES = 25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       set_mode,
   input  logic       inc_btn,
   input  logic       dec_btn,
   output logic [3:0] rightMin,
   output logic [2:0] leftMin,
   output logic       hour_carry,
   output logic       set_active
);

   localparam int         RW          = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_CYCLES - 1);
   localparam logic [7:0] SEC_LAST    = 8'(TICKS_PER_MIN - 1);

   state_t        state;
   logic [7:0]    secCnt;
   logic [RW-1:0] repeatCnt;
   logic [RW-1:0] repeatNext;
   logic          incPrev;
   logic          decPrev;
   logic          stepInc;
   logic          stepDec;
   logic          tickAdvance;
   logic [2:0]    nextLeft;
   logic [3:0]    nextRight;
   logic          wrap;

   // Button stepping: a fresh press steps at once; a steady single hold steps
   // every REPEAT_CYCLES edges. Both buttons or none held clears the count.
   always_comb begin
      stepInc    = 1'b0;
      stepDec    = 1'b0;
      repeatNext = '0;
      if (state == SET && (inc_btn ^ dec_btn)) begin
         if ((inc_btn && !incPrev) || (dec_btn && !decPrev) || repeatCnt == REPEAT_LAST) begin
            stepInc = inc_btn;
            stepDec = dec_btn;
         end else begin
            repeatNext = repeatCnt + RW'(1);
         end
      end
   end

   // The RUN->SET edge clears the seconds and ignores the tick.
   assign tickAdvance = (state == RUN) && !set_mode && tick && (secCnt == SEC_LAST);

   minutes_bcd_step u_step (
      .leftMin  (leftMin),
      .rightMin (rightMin),
      .inc      (stepInc | tickAdvance),
      .dec      (stepDec),
      .nextLeft (nextLeft),
      .nextRight(nextRight),
      .wrap     (wrap)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RUN;
         secCnt     <= 8'd0;
         repeatCnt  <= '0;
         incPrev    <= 1'b0;
         decPrev    <= 1'b0;
         rightMin   <= 4'd0;
         leftMin    <= 3'd0;
         hour_carry <= 1'b0;
         set_active <= 1'b0;
      end else begin
         state      <= set_mode ? SET : RUN;
         set_active <= set_mode;
         incPrev    <= inc_btn;
         decPrev    <= dec_btn;
         repeatCnt  <= repeatNext;
         rightMin   <= nextRight;
         leftMin    <= nextLeft;
         hour_carry <= tickAdvance && wrap;
         if (state == RUN) begin
            if (set_mode) begin
               secCnt <= 8'd0;
            end else if (tick) begin
               secCnt <= (secCnt == SEC_LAST) ? 8'd0 : secCnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_minutes_counter.sv
// Self-checking bench: directed scenarios plus random stimulus against a
// behavioural minutes model (integer minutes 0..59, integer seconds).
module tb_minutes_counter;

   localparam int T = 4;
   localparam int R = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       set_mode = 1'b0;
   logic       inc_btn = 1'b0;
   logic       dec_btn = 1'b0;
   logic [3:0] rightMin;
   logic [2:0] leftMin;
   logic       hour_carry;
   logic       set_active;

   int total = 0;
   int bad = 0;

   // behavioural model state
   int mMin = 0;
   int mSec = 0;
   int mSet = 0;
   int mHeld = 0;
   int mIncPrev = 0;
   int mDecPrev = 0;
   int mCarry = 0;
   bit checkOn = 1'b0;

   minutes_counter #(.TICKS_PER_MIN(T), .REPEAT_CYCLES(R)) dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .set_mode  (set_mode),
      .inc_btn   (inc_btn),
      .dec_btn   (dec_btn),
      .rightMin  (rightMin),
      .leftMin   (leftMin),
      .hour_carry(hour_carry),
      .set_active(set_active)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: minutes as an integer, stepping by arithmetic modulo 60.
   always @(posedge clk) begin
      if (rst) begin
         mMin = 0; mSec = 0; mSet = 0; mHeld = 0;
         mIncPrev = 0; mDecPrev = 0; mCarry = 0;
         checkOn = 1'b1;
      end else begin
         mCarry = 0;
         if (mSet == 0) begin
            mHeld = 0;
            if (set_mode) begin
               mSec = 0;
            end else if (tick) begin
               mSec = mSec + 1;
               if (mSec == T) begin
                  mSec = 0;
                  if (mMin == 59) mCarry = 1;
                  mMin = (mMin + 1) % 60;
               end
            end
         end else begin
            if (inc_btn != dec_btn) begin
               int dir;
               bit fresh;
               dir   = inc_btn ? 1 : 59;
               fresh = inc_btn ? (mIncPrev == 0) : (mDecPrev == 0);
               if (fresh) begin
                  mHeld = 0;
                  mMin = (mMin + dir) % 60;
               end else begin
                  mHeld = mHeld + 1;
                  if (mHeld == R) begin
                     mHeld = 0;
                     mMin = (mMin + dir) % 60;
                  end
               end
            end else begin
               mHeld = 0;
            end
         end
         mSet = set_mode ? 1 : 0;
         mIncPrev = inc_btn ? 1 : 0;
         mDecPrev = dec_btn ? 1 : 0;
      end
   end

   // Single compare process, away from the active edge.
   always @(negedge clk) begin
      if (checkOn) begin
         check("model_rightMin", 32'(rightMin), 32'(mMin % 10));
         check("model_leftMin", 32'(leftMin), 32'(mMin / 10));
         check("model_hour_carry", 32'(hour_carry), 32'(mCarry));
         check("model_set_active", 32'(set_active), 32'(mSet));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pressInc(input int n);
      for (int i = 0; i < n; i++) begin
         inc_btn = 1'b1; step(1);
         inc_btn = 1'b0; step(1);
      end
   endtask

   task automatic expectMin(input string name, input int minutes);
      check({name, "_lo"}, 32'(rightMin), 32'(minutes % 10));
      check({name, "_hi"}, 32'(leftMin), 32'(minutes / 10));
   endtask

   initial begin
      @(negedge clk);
      step(2);
      rst = 1'b0;
      check("reset_right", 32'(rightMin), 32'd0);
      check("reset_left", 32'(leftMin), 32'd0);
      check("reset_set_active", 32'(set_active), 32'd0);
      check("reset_carry", 32'(hour_carry), 32'd0);

      // four ticks in RUN -> 01 on the 4th tick edge
      tick = 1'b1; step(3);
      expectMin("run_3ticks", 0);
      step(1); tick = 1'b0;
      expectMin("run_4ticks", 1);

      // enter SET, two dec presses: 01 -> 00 -> 59
      set_mode = 1'b1; step(1);
      check("set_active_on", 32'(set_active), 32'd1);
      dec_btn = 1'b1; step(2); dec_btn = 1'b0; step(1);
      expectMin("dec_to_00", 0);
      dec_btn = 1'b1; step(1);
      expectMin("dec_wrap_59", 59);
      step(1); dec_btn = 1'b0; step(1);
      inc_btn = 1'b1; step(1);
      expectMin("inc_wrap_00", 0);
      inc_btn = 1'b0; step(1);
      dec_btn = 1'b1; step(1); dec_btn = 1'b0; step(1);
      expectMin("preload_59", 59);

      // back to RUN: 4 ticks -> 00 with a one-cycle carry
      set_mode = 1'b0; step(1);
      check("set_active_off", 32'(set_active), 32'd0);
      tick = 1'b1; step(3);
      expectMin("carry_pre", 59);
      step(1); tick = 1'b0;
      expectMin("carry_rollover", 0);
      check("carry_high", 32'(hour_carry), 32'd1);
      step(1);
      check("carry_low", 32'(hour_carry), 32'd0);

      // SET at 09, hold inc: 10 @1, 11 @9, 12 @17, 13 @25
      set_mode = 1'b1; step(1);
      pressInc(9);
      expectMin("at_09", 9);
      inc_btn = 1'b1; step(1);
      expectMin("hold_c1", 10);
      step(8); expectMin("hold_c9", 11);
      step(8); expectMin("hold_c17", 12);
      step(8); expectMin("hold_c25", 13);
      step(5); expectMin("hold_c30", 13);
      inc_btn = 1'b0; step(1);

      // both buttons together, then ticks in SET: no change
      inc_btn = 1'b1; dec_btn = 1'b1; step(12);
      expectMin("both_pressed", 13);
      inc_btn = 1'b0; dec_btn = 1'b0;
      tick = 1'b1; step(10); tick = 1'b0;
      expectMin("ticks_in_set", 13);
      check("set_no_carry", 32'(hour_carry), 32'd0);

      // reset during an inc hold at 37
      pressInc(23);
      expectMin("at_36", 36);
      inc_btn = 1'b1; step(1);
      expectMin("hold_37", 37);
      step(4);
      rst = 1'b1; step(1);
      expectMin("rst_mid_hold", 0);
      rst = 1'b0; step(5);
      expectMin("after_rst_hold", 0);
      inc_btn = 1'b0; step(1);
      inc_btn = 1'b1; step(1);
      expectMin("fresh_press", 1);
      inc_btn = 1'b0; step(1);

      // randomized phase
      for (int c = 0; c < 4000; c++) begin
         rst  = ($urandom_range(299) == 0);
         tick = ($urandom_range(2) == 0);
         if ($urandom_range(39) == 0) set_mode = ~set_mode;
         if ($urandom_range(14) == 0) inc_btn = ~inc_btn;
         if ($urandom_range(14) == 0) dec_btn = ~dec_btn;
         step(1);
      end
      rst = 1'b0; step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/minutes_counter.md
MINUTES_COUNTER -- requirements
Module: minutes_counter

Interface
REQ-001 Parameter: TICKS_PER_MIN, 60, tick pulses per minute (range 2..255).
REQ-002 Parameter: REPEAT_CYCLES, 25_000_000, clock cycles a held button waits before and between auto-repeat steps.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: tick  input  1  one-cycle enable pulse, nominally 1 Hz; synchronous to clk.
REQ-006 Port: set_mode  input  1  level; 1 requests SET state, 0 requests RUN state.
REQ-007 Port: inc_btn  input  1  debounced, synchronous level; pressed = 1.
REQ-008 Port: dec_btn  input  1  debounced, synchronous level; pressed = 1.
REQ-009 Port: rightMin  output  4  BCD minutes units digit, 0..9; feeds the minutes display controller.
REQ-010 Port: leftMin  output  3  BCD minutes tens digit, 0..5; feeds the minutes display controller.
REQ-011 Port: hour_carry  output  1  one-cycle pulse on a 59->00 rollover in RUN.
REQ-012 Port: set_active  output  1  1 while the FSM is in SET.

Function
REQ-013 The FSM SHALL have exactly two states: RUN and SET.
REQ-014 RUN->SET SHALL occur on the edge that samples set_mode=1, and SET->RUN on the edge that samples set_mode=0.
REQ-015 In RUN, the seconds counter (0..TICKS_PER_MIN-1) SHALL increment on each tick.
REQ-016 In RUN, a tick with the seconds counter at TICKS_PER_MIN-1 SHALL reload it to 0 and advance the minutes by one on the same edge.
REQ-017 A minutes advance SHALL be BCD: units 9->0 with tens+1; at 59 the value SHALL go to 00.
REQ-018 In RUN, a 59->00 advance SHALL assert hour_carry for exactly the following cycle; hour_carry SHALL be 0 otherwise.
REQ-019 Entering SET SHALL clear the seconds counter to 0; in SET, tick SHALL be ignored and hour_carry SHALL stay 0.
REQ-020 In SET, a rising edge of inc_btn (current=1, registered copy=0) SHALL add one minute, wrapping 59->00 with no carry.
REQ-021 In SET, a rising edge of dec_btn SHALL subtract one minute, wrapping 00->59.
REQ-022 Button step latency: the output SHALL change on the clock edge that first samples the button high, so it is visible one cycle after the input rises.
REQ-023 With exactly one button held continuously in SET, a repeat counter SHALL cause an additional step after REPEAT_CYCLES cycles, then one step every REPEAT_CYCLES cycles.
REQ-024 Releasing the button SHALL clear the repeat counter.
REQ-025 If inc_btn and dec_btn are both high, minutes SHALL NOT change and the repeat counter SHALL clear.
REQ-026 In RUN, buttons SHALL be ignored, but their registered copies SHALL still update, so that pressing before entering SET gives no step on entry.
REQ-027 rightMin and leftMin SHALL be registered outputs and SHALL never leave 0..9 and 0..5 respectively.
REQ-028 set_active SHALL be 1 exactly when the state is SET.

Reset
REQ-029 While rst=1 at a clock edge: state=RUN, seconds=0, rightMin=0, leftMin=0, hour_carry=0, set_active=0, repeat counter=0, button registers=0.
REQ-030 rst SHALL override every other input on the same edge, including tick, buttons and set_mode.
REQ-031 Reset asserted mid-repeat or mid-minute SHALL discard all partial counts, with no pending step or carry afterwards.

Structure
REQ-032 A shared package clock_pkg SHALL hold the state enum (RUN, SET) and the digit limits (units max 9, tens max 5).
REQ-033 A sub-module minutes_bcd_step SHALL compute the next {leftMin, rightMin} plus a wrap flag, from the current value and inc/dec controls; it SHALL be purely combinational.
REQ-034 The seconds counter, repeat counter, FSM and output registers SHALL live in minutes_counter.

Verification (TICKS_PER_MIN=4, REPEAT_CYCLES=8)
REQ-035 Scenario: reset, then 4 ticks in RUN -> minutes 00->01 on the 4th tick edge; hour_carry stays 0.
REQ-036 Scenario: preload 59 via SET, return to RUN, 4 ticks -> rightMin=0, leftMin=0; hour_carry high for exactly 1 cycle.
REQ-037 Scenario: SET at 00, one dec_btn press for 2 cycles -> 59; inc_btn press -> 00; hour_carry stays 0 throughout.
REQ-038 Scenario: SET at 09, hold inc_btn for 30 cycles -> 10 at cycle 1, 11 at 9, 12 at 17, 13 at 25.
REQ-039 Scenario: SET with inc_btn and dec_btn pressed on the same cycle -> no change; 10 ticks in SET -> no change.
REQ-040 Scenario: rst pulsed during an inc_btn hold at 37 -> 00 next cycle, no further step until a fresh press after reset.
